// File: rtl/db_stream_loader_if.sv
// Bundle of the loader's command, database-read and RAM-write signals.
// The master modport is the loader itself; slave is its environment.
interface db_stream_loader_if #(
    parameter int unsigned DW       = 11,
    parameter int unsigned PACK     = 9,
    parameter int unsigned ADDR_SRC = 13,
    parameter int unsigned ADDR_P   = 13,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned LEN_W    = 13,
    parameter int unsigned GRP_W    = 5
);
    // command channel
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_kind;
    logic [ADDR_SRC-1:0] cmd_src;
    logic [LEN_W-1:0]    cmd_len;
    logic [GRP_W-1:0]    cmd_group;
    // database ROM read port
    logic [ADDR_SRC-1:0] address;
    logic                re_db;
    logic [DW-1:0]       data;
    // pixel RAM write port
    logic                we_p;
    logic [ADDR_P-1:0]   addrp;
    logic [DW-1:0]       dp;
    // weight RAM write port
    logic                we_w;
    logic [ADDR_W-1:0]   addrw;
    logic [PACK*DW-1:0]  dw;
    // status
    logic                busy;
    logic                done;

    modport master (
        input  cmd_valid, cmd_kind, cmd_src, cmd_len, cmd_group, data,
        output cmd_ready, address, re_db, we_p, addrp, dp, we_w, addrw, dw, busy, done
    );

    modport slave (
        output cmd_valid, cmd_kind, cmd_src, cmd_len, cmd_group, data,
        input  cmd_ready, address, re_db, we_p, addrp, dp, we_w, addrw, dw, busy, done
    );
endinterface

// File: rtl/db_stream_loader.sv
// Command-driven loader: streams one database segment per command into either
// the pixel RAM (one word per write) or the weight RAM (MSB-first lane packing
// with zero-padded flush at group boundary or end of segment).
module db_stream_loader #(
    parameter int unsigned DW       = 11,
    parameter int unsigned PACK     = 9,
    parameter int unsigned ADDR_SRC = 13,
    parameter int unsigned ADDR_P   = 13,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned LEN_W    = 13,
    parameter int unsigned GRP_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    db_stream_loader_if.master  bus
);
    localparam int unsigned LaneW = $clog2(PACK + 1);
    localparam int unsigned WordW = PACK * DW;

    typedef enum logic [2:0] {StIdle, StRead, StDrain, StFlush, StDone} state_e;

    state_e              state_q, state_d;
    logic                kind_q;
    logic [ADDR_SRC-1:0] src_q;
    logic [LEN_W-1:0]    len_q;
    logic [LaneW-1:0]    grp_q;
    logic [LEN_W-1:0]    rd_cnt_q;
    logic                rd_vld_q;   // database word for the previous read is on bus.data
    logic [LaneW-1:0]    lane_q;
    logic [WordW-1:0]    buf_q;
    logic [ADDR_P-1:0]   pix_idx_q;
    logic [ADDR_W-1:0]   w_idx_q;
    logic                we_p_q;
    logic [ADDR_P-1:0]   addrp_q;
    logic [DW-1:0]       dp_q;
    logic                we_w_q;
    logic [ADDR_W-1:0]   addrw_q;
    logic [WordW-1:0]    dw_q;

    logic [LaneW-1:0]    grp_eff;
    logic [WordW-1:0]    buf_ins;
    logic                accept;
    logic                last_rd;
    logic                lane_full;
    logic                flush_go;

    assign accept    = (state_q == StIdle) && bus.cmd_valid;
    assign last_rd   = (rd_cnt_q == len_q - LEN_W'(1));
    assign lane_full = (LaneW'(lane_q + LaneW'(1)) == grp_q);
    assign flush_go  = (state_q == StDrain) && !rd_vld_q && (lane_q != '0);

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.re_db     = (state_q == StRead);
    assign bus.done      = (state_q == StDone);
    assign bus.address   = src_q + ADDR_SRC'(rd_cnt_q);
    assign bus.we_p      = we_p_q;
    assign bus.addrp     = addrp_q;
    assign bus.dp        = dp_q;
    assign bus.we_w      = we_w_q;
    assign bus.addrw     = addrw_q;
    assign bus.dw        = dw_q;

    // Effective group size: 0 or anything at/above PACK means a full word.
    always_comb begin
        grp_eff = LaneW'(PACK);
        if (bus.cmd_group != '0 && 32'(bus.cmd_group) < PACK) begin
            grp_eff = LaneW'(bus.cmd_group);
        end
    end

    // Lane buffer with the returning word dropped into the current lane (lane 0 = MSBs).
    always_comb begin
        buf_ins = buf_q;
        for (int unsigned t = 0; t < PACK; t++) begin
            if (LaneW'(t) == lane_q) begin
                buf_ins[(PACK-1-t)*DW +: DW] = bus.data;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; drain waits until the last returned word has been written.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = (bus.cmd_len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (last_rd) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!rd_vld_q) begin
                    state_d = (lane_q != '0) ? StFlush : StDone;
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Command latch, read counter, capture pipeline and write-port registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q    <= 1'b0;
            src_q     <= '0;
            len_q     <= '0;
            grp_q     <= '0;
            rd_cnt_q  <= '0;
            rd_vld_q  <= 1'b0;
            lane_q    <= '0;
            buf_q     <= '0;
            pix_idx_q <= '0;
            w_idx_q   <= '0;
            we_p_q    <= 1'b0;
            addrp_q   <= '0;
            dp_q      <= '0;
            we_w_q    <= 1'b0;
            addrw_q   <= '0;
            dw_q      <= '0;
        end else begin
            we_p_q   <= 1'b0;
            we_w_q   <= 1'b0;
            rd_vld_q <= (state_q == StRead);

            if (accept) begin
                kind_q    <= bus.cmd_kind;
                src_q     <= bus.cmd_src;
                len_q     <= bus.cmd_len;
                grp_q     <= grp_eff;
                rd_cnt_q  <= '0;
                pix_idx_q <= '0;
                w_idx_q   <= '0;
                lane_q    <= '0;
                buf_q     <= '0;
            end

            if (state_q == StRead) begin
                rd_cnt_q <= rd_cnt_q + LEN_W'(1);
            end

            if (rd_vld_q) begin
                if (!kind_q) begin
                    we_p_q    <= 1'b1;
                    addrp_q   <= pix_idx_q;
                    dp_q      <= bus.data;
                    pix_idx_q <= pix_idx_q + ADDR_P'(1);
                end else if (lane_full) begin
                    we_w_q  <= 1'b1;
                    addrw_q <= w_idx_q;
                    dw_q    <= buf_ins;
                    w_idx_q <= w_idx_q + ADDR_W'(1);
                    lane_q  <= '0;
                    buf_q   <= '0;
                end else begin
                    buf_q  <= buf_ins;
                    lane_q <= lane_q + LaneW'(1);
                end
            end

            // Partial word at end of segment: unused lanes are already zero.
            if (flush_go) begin
                we_w_q  <= 1'b1;
                addrw_q <= w_idx_q;
                dw_q    <= buf_q;
                w_idx_q <= w_idx_q + ADDR_W'(1);
                lane_q  <= '0;
                buf_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_db_stream_loader.sv
// Randomised self-checking bench for db_stream_loader with a segment-level
// reference model (expected read/write lists computed per command).
module tb_db_stream_loader;
    localparam int unsigned DW       = 11;
    localparam int unsigned PACK     = 9;
    localparam int unsigned ADDR_SRC = 13;
    localparam int unsigned ADDR_P   = 13;
    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned LEN_W    = 13;
    localparam int unsigned GRP_W    = 5;
    localparam int unsigned WordW    = PACK * DW;
    localparam int          RomSize  = 1 << ADDR_SRC;

    typedef struct {
        int               cyc;
        int               addr;
        logic [WordW-1:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    ev_t  rd_q[$];
    ev_t  pw_q[$];
    ev_t  ww_q[$];
    logic [DW-1:0] rom [0:RomSize-1];

    always #5 clk = ~clk;

    db_stream_loader_if #(
        .DW(DW), .PACK(PACK), .ADDR_SRC(ADDR_SRC), .ADDR_P(ADDR_P),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .GRP_W(GRP_W)
    ) bus ();

    db_stream_loader #(
        .DW(DW), .PACK(PACK), .ADDR_SRC(ADDR_SRC), .ADDR_P(ADDR_P),
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .GRP_W(GRP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ROM model: one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.re_db) bus.data <= rom[bus.address];
    end

    // Event monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.re_db) rd_q.push_back('{cyc, int'(bus.address), '0});
            if (bus.we_p)  pw_q.push_back('{cyc, int'(bus.addrp), WordW'(bus.dp)});
            if (bus.we_w)  ww_q.push_back('{cyc, int'(bus.addrw), bus.dw});
            if (bus.we_p || bus.we_w) check("we_excl", bus.we_p & bus.we_w, 1'b0);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_log();
        rd_q.delete();
        pw_q.delete();
        ww_q.delete();
        done_cnt = 0;
    endtask

    task automatic drive_cmd(input bit kind, input int src, input int len, input int grp);
        bus.cmd_valid = 1'b1;
        bus.cmd_kind  = kind;
        bus.cmd_src   = ADDR_SRC'(src);
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_group = GRP_W'(grp);
    endtask

    task automatic run_cmd(input bit kind, input int src, input int len, input int grp);
        int acc;
        int l;
        int nw;
        int idx;
        int exp_done;
        logic [WordW-1:0] e;
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) begin
            @(negedge clk); #1;
        end
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(negedge clk); #1;
        clear_log();
        drive_cmd(kind, src, len, grp);
        acc = cyc;
        @(negedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("busy_after_accept", {bus.busy, bus.cmd_ready}, 2'b10);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        check("done_seen", done_cnt != 0, 1'b1);
        repeat (3) begin
            @(negedge clk); #1;
        end
        check("done_once", done_cnt, 1);
        check("idle_after", {bus.busy, bus.cmd_ready}, 2'b01);

        l = (grp == 0 || grp >= int'(PACK)) ? int'(PACK) : grp;
        check("rd_count", rd_q.size(), len);
        for (int k = 0; k < len && k < rd_q.size(); k++) begin
            check("rd_addr", rd_q[k].addr, (src + k) % RomSize);
            check("rd_cyc", rd_q[k].cyc, acc + 1 + k);
        end
        exp_done = acc + 1;
        if (!kind) begin
            check("pw_count", pw_q.size(), len);
            check("ww_none", ww_q.size(), 0);
            for (int k = 0; k < len && k < pw_q.size(); k++) begin
                check("pw_addr", pw_q[k].addr, k % (1 << ADDR_P));
                check("pw_data", pw_q[k].d, WordW'(rom[(src + k) % RomSize]));
                check("pw_cyc", pw_q[k].cyc, acc + 3 + k);
            end
            if (len > 0) exp_done = acc + 3 + len;
        end else begin
            nw = (len + l - 1) / l;
            check("ww_count", ww_q.size(), nw);
            check("pw_none", pw_q.size(), 0);
            for (int i = 0; i < nw && i < ww_q.size(); i++) begin
                e = '0;
                for (int t = 0; t < int'(PACK); t++) begin
                    idx = i * l + t;
                    e = e << DW;
                    if (t < l && idx < len) e[DW-1:0] = rom[(src + idx) % RomSize];
                end
                check("ww_addr", ww_q[i].addr, i % (1 << ADDR_W));
                check("ww_data", ww_q[i].d, e);
            end
            if (len > 0) exp_done = acc + 3 + len + ((len % l) != 0 ? 1 : 0);
        end
        check("done_cyc", done_cyc, exp_done);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = 1'b0;
        bus.cmd_src   = '0;
        bus.cmd_len   = '0;
        bus.cmd_group = '0;
        for (int a = 0; a < RomSize; a++) rom[a] = DW'(a - 90);
        repeat (3) @(negedge clk);
        #1;
        check("rst_strobes", {bus.re_db, bus.we_p, bus.we_w, bus.busy, bus.done}, 5'b0);
        check("rst_buses", {bus.address, bus.addrp, bus.dp, bus.addrw, bus.dw}, '0);
        check("rst_ready", bus.cmd_ready, 1'b1);
        rst = 1'b0;

        // Directed: pixel copy of ROM[100..103] = 10..13.
        run_cmd(1'b0, 100, 4, 0);

        for (int a = 0; a < RomSize; a++) rom[a] = DW'($urandom);
        run_cmd(1'b1, 200, 18, 0);
        run_cmd(1'b1, 300, 10, 0);
        run_cmd(1'b1, 400, 12, 4);
        run_cmd(1'b1, 500, 12, 20);
        run_cmd(1'b0, 600, 0, 0);
        run_cmd(1'b1, 700, 0, 3);
        run_cmd(1'b0, 8190, 5, 0);
        run_cmd(1'b1, 8189, 7, 3);

        // Reset in the middle of a weight segment: the partial word is discarded.
        @(negedge clk); #1;
        clear_log();
        drive_cmd(1'b1, 1000, 18, 0);
        @(negedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 50 && rd_q.size() < 7; i++) begin
            @(negedge clk); #1;
        end
        check("mid_reads", rd_q.size(), 7);
        rst = 1'b1;
        #1;
        check("mid_rst_strobes", {bus.re_db, bus.we_p, bus.we_w, bus.busy, bus.done}, 5'b0);
        check("mid_rst_buses", {bus.address, bus.addrw, bus.dw}, '0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        check("mid_no_ww", ww_q.size(), 0);
        check("mid_ready", bus.cmd_ready, 1'b1);
        run_cmd(1'b1, 1100, 9, 0);

        for (int n = 0; n < 12; n++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, RomSize - 1)),
                    int'($urandom_range(0, 30)), int'($urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/db_stream_loader.md
Name: db_stream_loader

Overview:
Parametrised command-driven loader that streams words from the database ROM into the pixel RAM and the packed-weight RAM. Each command names one segment: source base, length, kind and an optional group size. Pixel segments are copied one word per write. Weight segments are packed MSB-first into PACK-lane words, with zero-padded flush on group boundary or end of segment. It replaces the fixed step sequencer and sits between the database ROM and the RAM write ports; a top-level sequencer issues one command per layer.

Parameters:
DW, 11, width of one database word / pixel / weight lane
PACK, 9, weight lanes per packed weight word (dw width = PACK*DW)
ADDR_SRC, 13, database address width
ADDR_P, 13, pixel RAM address width
ADDR_W, 9, weight RAM address width
LEN_W, 13, segment length field width
GRP_W, 5, group size field width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at a rising edge
cmd_kind  in  1  0 = pixel segment, 1 = weight segment
cmd_src  in  ADDR_SRC  first database address
cmd_len  in  LEN_W  source words in segment; 0 = no-op
cmd_group  in  GRP_W  weight words per packed word; 0 or >=PACK means PACK
address  out  ADDR_SRC  database read address
re_db  out  1  database read strobe; data valid exactly one cycle later
data  in  DW  signed database word
we_p  out  1  pixel write strobe
addrp  out  ADDR_P  pixel write address
dp  out  DW  pixel write data
we_w  out  1  weight write strobe
addrw  out  ADDR_W  weight write address
dw  out  PACK*DW  packed weight data
busy  out  1  command in progress
done  out  1  one-cycle pulse at segment completion

Behaviour:
- Reset (async, any time): state IDLE, cmd_ready=1; all other outputs 0; lane buffer, counters and in-flight read discarded; no partial flush.
- States: IDLE -> READ -> DRAIN -> (FLUSH, weight with partial lanes only) -> DONE -> IDLE.
- IDLE: cmd_ready=1. On accept, latch kind/src/len/effective group L = (cmd_group==0 || cmd_group>=PACK) ? PACK : cmd_group.
- Accept with cmd_len==0: go to DONE; done pulses the next cycle; no reads, no writes.
- READ: starts the cycle after accept. re_db=1 every cycle. address=cmd_src+k for k=0..len-1, modulo 2^ADDR_SRC. Stays len cycles, then DRAIN.
- Pixel path: word k captured the cycle after its read. we_p=1 the following cycle with dp=word k, addrp=k mod 2^ADDR_P. Issue-to-write latency is 2 cycles; throughput is 1 word/cycle.
- Weight path: word k is written into lane j, the current lane count. Lane 0 occupies bits [PACK*DW-1 : (PACK-1)*DW], lane j occupies [(PACK-j)*DW-1 : (PACK-j-1)*DW].
- When j reaches L: we_w=1 for one cycle with dw=buffer (lanes >=L are 0). addrw=current weight index, which then increments mod 2^ADDR_W. Buffer clears and j resets to 0. A full word is emitted with the same 2-cycle latency as the pixel path.
- Destination counters addrp and addrw restart at 0 on every accepted command.
- DRAIN: waits for the last returned word to be written. If j>0 (weight), goes to FLUSH; otherwise goes to DONE.
- FLUSH: one we_w with lanes >=j zero, then DONE. Total weight writes per command = ceil(len/L).
- DONE: done=1 for one cycle the cycle after the last write; then IDLE.
- busy=1 from the cycle after accept through the DONE cycle inclusive. cmd_ready=0 while busy.
- we_p and we_w are never both 1. Strobes are single-cycle; addresses and data are held until the next write.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, cmd_ready=1 after release.
- Pixel: src=100, len=4, ROM[a]=a-90 -> re_db 4 cycles at address 100..103; we_p on 4 consecutive cycles with addrp 0..3, dp 10..13; first we_p 2 cycles after first re_db; done 1 cycle after last we_p.
- Weight full: len=18, group=0, ROM words w0..w17 -> exactly 2 we_w at addrw 0,1; word 0 lane0 (MSBs)=w0 ... lane8=w8; word 1 holds w9..w17.
- Weight tail: len=10, group=0 -> 2 we_w; second dw has lane0=w9 and lanes1..8=0.
- Grouped: len=12, group=4 -> 3 we_w at addrw 0..2, each with lanes0..3=next four words, lanes4..8=0. Also group=20 behaves as 9.
- Reset mid-weight after 5 words returned -> no we_w emitted. Next command (len=9) writes addrw=0. A len=0 command gives done 1 cycle after accept with no re_db.
